// File: rtl/jk_excite_driver_if.sv
// Target handshake bundle for jk_excite_driver.
// The master offers a target word; the slave (the driver) accepts it when ready.
interface jk_excite_driver_if #(
    parameter int unsigned WIDTH = 4
) ();

    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] tgt_data;

    // Producer of target words (testbench or upstream controller).
    modport master (
        output tgt_valid,
        output tgt_data,
        input  tgt_ready
    );

    // The excitation driver itself.
    modport slave (
        input  tgt_valid,
        input  tgt_data,
        output tgt_ready
    );

endinterface

// File: rtl/jk_excite_driver.sv
// JK excitation driver.
// Accepts a target word, drives J/K of an external JK flop bank for one cycle,
// checks the fed-back Q against the target and re-drives up to MAX_RETRY times.
// Reports a one-cycle done (match) or error (retries exhausted) pulse.
// Build option: define JK_TOGGLE_EN to drive mismatching bits with J=K=1 (toggle)
// instead of the default set/reset encoding; FSM and timing are unchanged.
module jk_excite_driver #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    jk_excite_driver_if.slave    tgt_if,
    output logic [WIDTH-1:0]     j_o,
    output logic [WIDTH-1:0]     k_o,
    input  logic [WIDTH-1:0]     q_fb_i,
    output logic                 done_o,
    output logic                 error_o,
    output logic                 busy_o
);

    // Retry counter must hold 0..MAX_RETRY; keep at least one bit for MAX_RETRY=0.
    localparam int unsigned       RetryW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

    // Reject out-of-range configurations at elaboration.
    if (WIDTH < 1 || WIDTH > 16) begin : gen_bad_width
        $error("jk_excite_driver: WIDTH must be in 1..16");
    end
    if (MAX_RETRY > 7) begin : gen_bad_retry
        $error("jk_excite_driver: MAX_RETRY must be in 0..7");
    end

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StCheck,
        StResp
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   target_q, target_d;
    logic [RetryW-1:0]  retry_q, retry_d;
    logic               match_q, match_d;

    logic [WIDTH-1:0]   drive_j;
    logic [WIDTH-1:0]   drive_k;
    logic               ready;

    // Excitation decode from current feedback and latched target.
    always_comb begin
`ifdef JK_TOGGLE_EN
        // Toggle every differing bit; equal bits hold.
        drive_j = q_fb_i ^ target_q;
        drive_k = q_fb_i ^ target_q;
`else
        // Set bits that must rise, reset bits that must fall; never J=K=1.
        drive_j = ~q_fb_i & target_q;
        drive_k = q_fb_i & ~target_q;
`endif
    end

    // Next-state and output decode; everything defaults to the idle/hold value.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        retry_d  = retry_q;
        match_d  = match_q;
        ready    = 1'b0;
        done_o   = 1'b0;
        error_o  = 1'b0;
        j_o      = '0;
        k_o      = '0;

        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (tgt_if.tgt_valid) begin
                    target_d = tgt_if.tgt_data;
                    retry_d  = '0;
                    state_d  = StDrive;
                end
            end
            StDrive: begin
                // The external bank samples J/K on the edge that leaves this state.
                j_o     = drive_j;
                k_o     = drive_k;
                state_d = StCheck;
            end
            StCheck: begin
                if (q_fb_i == target_q) begin
                    match_d = 1'b1;
                    state_d = StResp;
                end else if (retry_q < RetryMax) begin
                    retry_d = retry_q + 1'b1;
                    state_d = StDrive;
                end else begin
                    match_d = 1'b0;
                    state_d = StResp;
                end
            end
            StResp: begin
                done_o  = match_q;
                error_o = ~match_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset; reset drops any in-flight target.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            target_q <= '0;
            retry_q  <= '0;
            match_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            retry_q  <= retry_d;
            match_q  <= match_d;
        end
    end

    assign tgt_if.tgt_ready = ready;
    assign busy_o           = (state_q != StIdle);

endmodule
